multi_timer: RTL and testbench

//  Parametrised multi-channel programmable interval timer for the FPGA top level.
//  One shared power-of-two prescaler drives NCH independent channels.

---
 rtl/timer_pkg.sv | 17 +
 rtl/multi_timer_if.sv | 34 +++
 rtl/timer_channel.sv | 83 ++++++++
 rtl/multi_timer.sv | 63 ++++++
 tb/tb_multi_timer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the multi-channel interval timer.
// Channel run state is an enum so checkers can observe it directly.
package timer_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 16;
    localparam int PW_DEF  = 10;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/multi_timer_if.sv
// Control/status bundle for multi_timer; master = controller, slave = timer.
// cfg_we, start, stop and irq_clr are single-clock strobes acted on at the next rising edge.
interface multi_timer_if
    import timer_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_period;
    logic           cfg_oneshot;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] irq_clr;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] irq;
    logic [NCH-1:0] running;
    logic [CW-1:0]  cur_count;
    ch_state_t      ch_state [NCH];

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop, irq_clr,
        input  tick, irq, running, cur_count, ch_state
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop, irq_clr,
        output tick, irq, running, cur_count, ch_state
    );

endinterface

// File: rtl/timer_channel.sv
// One timer channel: period/mode registers, counter and stop > start > expiry > count priority.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pre_tick,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_period,
    input  logic          cfg_oneshot,
    input  logic          start,
    input  logic          stop,
    input  logic          irq_clr,
    output logic          tick,
    output logic          irq,
    output logic          running,
    output logic [CW-1:0] cnt,
    output ch_state_t     state
);

    logic [CW-1:0] period;
    logic          oneshot;
    ch_state_t     state_n;
    logic [CW-1:0] cnt_n;
    logic          tick_n;
    logic          irq_n;
    logic [CW-1:0] eff_period;
    logic          wr_zero;
    logic          expire;

    // A write in this clock already counts for the start decision.
    assign eff_period = cfg_we ? cfg_period : period;
    assign wr_zero    = cfg_we && (cfg_period == '0);
    assign expire     = (period != '0) && (cnt >= (period - CW'(1)));
    assign running    = (state == CH_RUN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= CH_IDLE;
            cnt     <= '0;
            period  <= '0;
            oneshot <= MODE_PERIODIC;
            tick    <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tick  <= tick_n;
            irq   <= irq_n;
            if (cfg_we) begin
                period  <= cfg_period;
                oneshot <= cfg_oneshot;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tick_n  = 1'b0;
        irq_n   = irq & ~irq_clr;
        if (stop || wr_zero) begin
            state_n = CH_IDLE;
        end else if (start && (eff_period != '0)) begin
            cnt_n   = '0;
            state_n = CH_RUN;
        end else if ((state == CH_RUN) && pre_tick) begin
            if (expire) begin
                cnt_n  = '0;
                tick_n = 1'b1;
                irq_n  = 1'b1;
                if (oneshot == MODE_ONESHOT) begin
                    state_n = CH_IDLE;
                end
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel interval timer: shared power-of-two prescaler, cfg decode,
// NCH independent channels and the cur_count readback mux.
module multi_timer
    import timer_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int PW  = PW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    multi_timer_if.slave        bus
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           pre_tick;
    logic [NCH-1:0] tick_v;
    logic [NCH-1:0] irq_v;
    logic [NCH-1:0] run_v;
    logic [CW-1:0]  cnt_arr [NCH];
    ch_state_t      st      [NCH];

    // Free-running; channel starts never realign it.
    generate
        if (PW == 0) begin : g_nopre
            assign pre_tick = 1'b1;
        end else begin : g_pre
            logic [PW-1:0] pre_cnt;
            always_ff @(posedge clk) begin
                if (!reset) pre_cnt <= '0;
                else        pre_cnt <= pre_cnt + PW'(1);
            end
            assign pre_tick = &pre_cnt;
        end
    endgenerate

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        timer_channel #(.CW(CW)) u_ch (
            .clk         (clk),
            .reset       (reset),
            .pre_tick    (pre_tick),
            .cfg_we      (bus.cfg_we && (bus.cfg_ch == CHW'(i))),
            .cfg_period  (bus.cfg_period),
            .cfg_oneshot (bus.cfg_oneshot),
            .start       (bus.start[i]),
            .stop        (bus.stop[i]),
            .irq_clr     (bus.irq_clr[i]),
            .tick        (tick_v[i]),
            .irq         (irq_v[i]),
            .running     (run_v[i]),
            .cnt         (cnt_arr[i]),
            .state       (st[i])
        );
    end

    assign bus.tick      = tick_v;
    assign bus.irq       = irq_v;
    assign bus.running   = run_v;
    assign bus.ch_state  = st;
    assign bus.cur_count = (int'(bus.cfg_ch) < NCH) ? cnt_arr[bus.cfg_ch] : '0;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (NCH=2, CW=8, PW=2): hand-written timing
// sequences plus a table of single-step vectors with hand-computed outputs.
module tb_multi_timer;
  import timer_pkg::*;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int PW  = 2;
  localparam int NV  = 14;

  typedef struct {
    string      name;
    logic [0:0] ch;
    logic       we;
    logic [7:0] period;
    logic       oneshot;
    logic [1:0] start;
    logic [1:0] stop;
    logic [1:0] clr;
    int         idle;
    logic [1:0] tick;
    logic [1:0] irq;
    logic [1:0] running;
    logic [7:0] count;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  int   n_edge = 0;
  int   gap;
  logic [1:0] seen;
  vec_t vecs [NV];
  vec_t v;

  always #5 clk = ~clk;

  multi_timer_if #(.NCH(NCH), .CW(CW)) bus ();

  multi_timer #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // n_edge counts edges sampled out of reset; pre_tick edges are n_edge % 4 == 0.
  task automatic step();
    @(posedge clk);
    if (reset) n_edge++;
    else       n_edge = 0;
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_we      = 1'b0;
    bus.cfg_period  = '0;
    bus.cfg_oneshot = 1'b0;
    bus.start       = '0;
    bus.stop        = '0;
    bus.irq_clr     = '0;
  endtask

  task automatic sync_phase();
    for (int i = 0; i < 4 && (n_edge % 4) != 0; i++) step();
  endtask

  task automatic wait_tick(input int ch, input int limit, output int g);
    g = 0;
    do begin
      step();
      g++;
    end while (!bus.tick[ch] && g < limit);
  endtask

  task automatic drive_cfg(input logic [0:0] ch, input logic [7:0] p, input logic os);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = ch;
    bus.cfg_period  = p;
    bus.cfg_oneshot = os;
  endtask

  function automatic vec_t mk(input string name, input logic [0:0] ch, input logic we,
                              input logic [7:0] period, input logic oneshot,
                              input logic [1:0] start, input logic [1:0] stop,
                              input logic [1:0] clr, input int idle,
                              input logic [1:0] tick, input logic [1:0] irq,
                              input logic [1:0] running, input logic [7:0] count);
    vec_t r;
    r.name = name; r.ch = ch; r.we = we; r.period = period; r.oneshot = oneshot;
    r.start = start; r.stop = stop; r.clr = clr; r.idle = idle;
    r.tick = tick; r.irq = irq; r.running = running; r.count = count;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name              ch we per os  start  stop   clr   idle tick   irq    run    cnt
    vecs[0]  = mk("stop0",          0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0,  2'b00, 2'b01, 2'b00, 0);
    vecs[1]  = mk("os1_start",      1, 1, 2, 1, 2'b10, 2'b00, 2'b00, 0,  2'b00, 2'b01, 2'b10, 0);
    vecs[2]  = mk("os1_cnt1",       1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1,  2'b00, 2'b01, 2'b10, 1);
    vecs[3]  = mk("os1_hold",       1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2,  2'b00, 2'b01, 2'b10, 1);
    vecs[4]  = mk("os1_expire",     1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0,  2'b10, 2'b11, 2'b00, 0);
    vecs[5]  = mk("clr0",           1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 0,  2'b00, 2'b10, 2'b00, 0);
    vecs[6]  = mk("os1_quiet",      1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 49, 2'b00, 2'b10, 2'b00, 0);
    vecs[7]  = mk("start_wr_p0",    0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0,  2'b00, 2'b10, 2'b00, 0);
    vecs[8]  = mk("start_p0",       0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0,  2'b00, 2'b10, 2'b00, 0);
    vecs[9]  = mk("stop_start",     0, 1, 5, 0, 2'b01, 2'b01, 2'b00, 0,  2'b00, 2'b10, 2'b00, 0);
    vecs[10] = mk("start5",         0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0,  2'b00, 2'b10, 2'b01, 0);
    vecs[11] = mk("count2",         0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 7,  2'b00, 2'b10, 2'b01, 2);
    vecs[12] = mk("restart_on_pre", 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0,  2'b00, 2'b10, 2'b01, 0);
    vecs[13] = mk("count1",         0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3,  2'b00, 2'b10, 2'b01, 1);

    bus.cfg_ch = '0;
    idle_inputs();

    // Reset, then quiet run with no starts.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("rst_outputs", {bus.tick, bus.irq, bus.running, bus.cur_count}, 32'h0);
    check("rst_state0", {31'b0, bus.ch_state[0] == CH_RUN}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("quiet", {bus.tick, bus.irq, bus.running, bus.cur_count}, 32'h0);
    end

    // ch0 period 3 periodic: first tick 11 edges after a phase-1 start, then every 12.
    sync_phase();
    drive_cfg(0, 8'd3, MODE_PERIODIC);
    bus.start = 2'b01;
    step();
    idle_inputs();
    check("p3_running", {31'b0, bus.running[0]}, 32'h1);
    check("p3_count0", {24'b0, bus.cur_count}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      wait_tick(0, 40, gap);
      check("p3_gap", gap, (k == 0) ? 32'd11 : 32'd12);
      check("p3_irq", {31'b0, bus.irq[0]}, 32'h1);
      check("p3_run", {31'b0, bus.running[0]}, 32'h1);
    end

    // irq_clr on an expiry edge loses to the set; alone it clears.
    for (int i = 0; i < 11; i++) step();
    bus.irq_clr = 2'b01;
    step();
    idle_inputs();
    check("clr_tick", {31'b0, bus.tick[0]}, 32'h1);
    check("clr_set_wins", {31'b0, bus.irq[0]}, 32'h1);
    bus.irq_clr = 2'b01;
    step();
    idle_inputs();
    check("clr_alone", {31'b0, bus.irq[0]}, 32'h0);
    check("tick_one_clk", {31'b0, bus.tick[0]}, 32'h0);

    // ch0 period 10 reaches cnt 5, then period 2 expires at the next pre_tick.
    sync_phase();
    drive_cfg(0, 8'd10, MODE_PERIODIC);
    bus.start = 2'b01;
    step();
    idle_inputs();
    for (int i = 0; i < 19; i++) step();
    check("p10_cnt5", {24'b0, bus.cur_count}, 32'd5);
    drive_cfg(0, 8'd2, MODE_PERIODIC);
    step();
    idle_inputs();
    check("rewr_no_tick", {31'b0, bus.tick[0]}, 32'h0);
    check("rewr_cnt_hold", {24'b0, bus.cur_count}, 32'd5);
    for (int k = 0; k < 3; k++) begin
      wait_tick(0, 40, gap);
      check("rewr_gap", gap, (k == 0) ? 32'd3 : 32'd8);
      check("rewr_cnt0", {24'b0, bus.cur_count}, 32'd0);
    end

    // Single-step vector table, starting one edge after a pre_tick edge.
    sync_phase();
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      bus.cfg_ch      = v.ch;
      bus.cfg_we      = v.we;
      bus.cfg_period  = v.period;
      bus.cfg_oneshot = v.oneshot;
      bus.start       = v.start;
      bus.stop        = v.stop;
      bus.irq_clr     = v.clr;
      step();
      seen = bus.tick;
      idle_inputs();
      for (int k = 0; k < v.idle; k++) begin
        step();
        seen |= bus.tick;
      end
      check({v.name, ".tick"}, {30'b0, seen}, {30'b0, v.tick});
      check({v.name, ".irq"}, {30'b0, bus.irq}, {30'b0, v.irq});
      check({v.name, ".running"}, {30'b0, bus.running}, {30'b0, v.running});
      check({v.name, ".count"}, {24'b0, bus.cur_count}, {24'b0, v.count});
    end

    // Reset in the middle of a count clears everything and nothing restarts.
    bus.cfg_ch = 1'b0;
    reset = 1'b0;
    step();
    check("midrst_outputs", {bus.tick, bus.irq, bus.running, bus.cur_count}, 32'h0);
    check("midrst_state0", {31'b0, bus.ch_state[0] == CH_RUN}, 32'h0);
    reset = 1'b1;
    seen = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= bus.tick;
    end
    check("postrst_tick", {30'b0, seen}, 32'h0);
    check("postrst_run_irq", {28'b0, bus.running, bus.irq}, 32'h0);
    bus.cfg_ch = 1'b1;
    #1;
    check("postrst_cnt1", {24'b0, bus.cur_count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
